// File: rtl/seq_det_ctrl_if.sv
// Config/control/serial-data bundle between the test/config master and seq_det_ctrl.
// Config handshake is valid/ready; the serial stream is qualified by din_valid and never stalls.
interface seq_det_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_limit;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic               din;
  logic               din_valid;
  logic               dout;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    output start, stop, din, din_valid,
    input  cfg_ready, cfg_err, dout, busy, done, match_cnt
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    input  start, stop, din, din_valid,
    output cfg_ready, cfg_err, dout, busy, done, match_cnt
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector: dout pulses one cycle after the matching sampling edge.
// Config is accepted in one cycle whenever not running (cfg_ready low only in RUN); din never stalls.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic          clk,
  input logic          rst,
  seq_det_ctrl_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W:0]   FILL_ONE = (LEN_W + 1)'(1);
  localparam logic [LEN_W:0]   FILL_MAX = (LEN_W + 1)'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   lim_q;
  logic               loaded_q;
  logic               cfg_err_q;
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               dout_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               cfg_xfer;
  logic               cfg_bad;
  logic               start_ok;
  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               match_hit;

  assign cfg_xfer = bus.cfg_valid && (state_q != RUN);
  assign cfg_bad  = (bus.cfg_len < LEN_W'(2)) || (bus.cfg_len > LEN_W'(MAX_LEN));
  assign start_ok = bus.start && loaded_q && !cfg_err_q;

  // Only len-1 past bits are ever compared, so history holds MAX_LEN-1 bits.
  assign hist_d   = {hist_q, bus.din};
  assign fill_inc = {1'b0, fill_q} + FILL_ONE;
  assign fill_d   = (fill_inc > FILL_MAX) ? LEN_W'(MAX_LEN) : fill_inc[LEN_W-1:0];
  assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign match_hit = bus.din_valid && (fill_inc >= {1'b0, len_q}) &&
                     (((hist_d ^ pat_q) & len_mask) == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      lim_q     <= '0;
      loaded_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      dout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      dout_q <= 1'b0;
      if (cfg_xfer) begin
        if (cfg_bad) begin
          cfg_err_q <= 1'b1;
        end else begin
          pat_q     <= bus.cfg_pattern;
          len_q     <= bus.cfg_len;
          ovl_q     <= bus.cfg_overlap;
          lim_q     <= bus.cfg_limit;
          cfg_err_q <= 1'b0;
          loaded_q  <= 1'b1;
        end
      end
      unique case (state_q)
        IDLE, DONE: begin
          // A config transfer takes priority; a start in the same cycle is dropped.
          if (cfg_xfer) begin
            state_q <= IDLE;
          end else if (start_ok) begin
            state_q <= RUN;
            cnt_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= IDLE;
          end else if (bus.din_valid) begin
            hist_q <= hist_d[MAX_LEN-2:0];
            if (match_hit) begin
              dout_q <= 1'b1;
              cnt_q  <= cnt_d;
              fill_q <= ovl_q ? fill_d : '0;
              if ((lim_q != '0) && (cnt_d == lim_q)) begin
                state_q <= DONE;
              end
            end else begin
              fill_q <= fill_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = (state_q != RUN);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.dout      = dout_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: expected dout pulses go into a queue that a negedge monitor drains.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;
  exp_t exp_q[$];

  seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk = n_chk + 1;
    if (act === expv) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit exp_m, input int exp_cnt);
    exp_t e;
    bus.din       = b;
    bus.din_valid = 1'b1;
    if (exp_m) begin
      e.cyc = cyc + 1;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
    tick();
    bus.din_valid = 1'b0;
    bus.din       = 1'b0;
  endtask

  task automatic gap();
    bus.din       = 1'b1;
    bus.din_valid = 1'b0;
    tick();
    bus.din = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic [7:0] lim);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.cfg_limit   = lim;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.dout === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("dout_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dout_cycle", cyc, e.cyc);
        check("dout_cnt", 32'(bus.match_cnt), e.cnt);
      end
    end
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len = '0;
    bus.cfg_overlap = 1'b0;
    bus.cfg_limit = '0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_cnt", 32'(bus.match_cnt), 0);
    check("rst_cfg_err", 32'(bus.cfg_err), 0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 1);
    rst = 1'b1;
    tick();

    // 1: pattern 101, non-overlapping
    do_cfg(8'b101, 4'd3, 1'b0, 8'd0);
    check("t1_cfg_err", 32'(bus.cfg_err), 0);
    pulse_start();
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_ready_run", 32'(bus.cfg_ready), 0);
    send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 1, 1);
    send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(0, 0, 0);
    send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(0, 0, 0);
    tick();
    check("t1_cnt", 32'(bus.match_cnt), 1);
    pulse_stop();
    check("t1_stop_busy", 32'(bus.busy), 0);
    check("t1_stop_cnt", 32'(bus.match_cnt), 1);

    // 2: same stream, overlapping
    do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    pulse_start();
    check("t2_cnt_cleared", 32'(bus.match_cnt), 0);
    send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 1, 1);
    send_bit(0, 0, 0); send_bit(1, 1, 2); send_bit(0, 0, 0);
    send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(0, 0, 0);
    tick();
    check("t2_cnt", 32'(bus.match_cnt), 2);
    pulse_stop();

    // 3: illegal lengths
    do_cfg(8'b11, 4'd0, 1'b0, 8'd0);
    check("t3_err_len0", 32'(bus.cfg_err), 1);
    pulse_start();
    check("t3_busy_len0", 32'(bus.busy), 0);
    do_cfg(8'b11, 4'd9, 1'b0, 8'd0);
    check("t3_err_len9", 32'(bus.cfg_err), 1);
    pulse_start();
    check("t3_busy_len9", 32'(bus.busy), 0);
    do_cfg(8'b11, 4'd1, 1'b0, 8'd0);
    check("t3_err_len1", 32'(bus.cfg_err), 1);

    // 4: pattern 11, overlap, limit 3
    do_cfg(8'b11, 4'd2, 1'b1, 8'd3);
    check("t4_err_clear", 32'(bus.cfg_err), 0);
    pulse_start();
    send_bit(1, 0, 0); send_bit(1, 1, 1); send_bit(1, 1, 2); send_bit(1, 1, 3);
    check("t4_done", 32'(bus.done), 1);
    check("t4_busy", 32'(bus.busy), 0);
    send_bit(1, 0, 0); send_bit(1, 0, 0);
    check("t4_cnt", 32'(bus.match_cnt), 3);
    pulse_stop();
    check("t4_stop_ignored", 32'(bus.done), 1);

    // 5: pattern 1010 with gaps, stop mid-stream, stop+start
    do_cfg(8'b1010, 4'd4, 1'b0, 8'd0);
    check("t5_done_cleared", 32'(bus.done), 0);
    pulse_start();
    send_bit(1, 0, 0); gap(); send_bit(0, 0, 0); gap(); gap();
    send_bit(1, 0, 0); gap(); send_bit(0, 1, 1); gap();
    check("t5_cnt_gaps", 32'(bus.match_cnt), 1);
    send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0);
    bus.stop = 1'b1;
    send_bit(0, 0, 0);
    bus.stop = 1'b0;
    check("t5_stop_busy", 32'(bus.busy), 0);
    check("t5_stop_cnt", 32'(bus.match_cnt), 1);
    tick();
    pulse_start();
    check("t5_restart_busy", 32'(bus.busy), 1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("t5_stopstart_busy", 32'(bus.busy), 0);
    tick();
    check("t5_stopstart_idle", 32'(bus.busy), 0);

    // 6: reset during a matching sample
    pulse_start();
    check("t6_busy", 32'(bus.busy), 1);
    send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0);
    rst = 1'b0;
    send_bit(0, 0, 0);
    rst = 1'b1;
    check("t6_cnt", 32'(bus.match_cnt), 0);
    check("t6_ready", 32'(bus.cfg_ready), 1);
    check("t6_busy_rst", 32'(bus.busy), 0);
    check("t6_dout", 32'(bus.dout), 0);
    tick();
    pulse_start();
    check("t6_start_unloaded", 32'(bus.busy), 0);
    do_cfg(8'b1010, 4'd4, 1'b0, 8'd0);
    pulse_start();
    check("t6_start_loaded", 32'(bus.busy), 1);
    pulse_stop();

    repeat (3) tick();
    check("exp_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
